// File: rtl/block_exec_pkg.sv
// rtl/block_exec_pkg.sv - shared opcode, state and width constants for block_exec
package block_exec_pkg;

    localparam int SIZE_OP_DEF = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/block_exec_mul.sv
// rtl/block_exec_mul.sv - iterative shift-add multiplier, one multiplier bit per cycle
module block_exec_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0]  count;
    logic [W-1:0]   mcand;
    logic [2*W-1:0] acc;
    logic [W:0]     upper_sum;
    logic [2*W-1:0] acc_next;

    // One shift-add step: add multiplicand to the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    always_comb begin
        upper_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next  = {upper_sum, acc[W-1:1]};
    end

    // done marks the cycle of the final step; product is that step's result.
    assign done    = (count == CW'(1));
    assign product = acc_next;

    // Load operands on start, then iterate until the counter runs out.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start) begin
            count <= CW'(W);
            mcand <= a;
            acc   <= {{W{1'b0}}, b};
        end else if (count != '0) begin
            count <= count - CW'(1);
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/block_exec.sv
// rtl/block_exec.sv - execute/writeback stage with forwarding; BLOCK_EXEC_MUL_EN adds the multiplier
module block_exec
    import block_exec_pkg::*;
#(
    parameter int SIZE_ADDR_REG = 5,
    parameter int SIZE_REG      = 8,
    parameter int SIZE_OP       = SIZE_OP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    output logic                     ready,
    input  logic [SIZE_OP-1:0]       op,
    input  logic [SIZE_ADDR_REG-1:0] dest,
    input  logic [SIZE_ADDR_REG-1:0] srcA,
    input  logic [SIZE_ADDR_REG-1:0] srcB,
    input  logic [SIZE_REG-1:0]      dataA,
    input  logic [SIZE_REG-1:0]      dataB,
    output logic                     charge,
    output logic [SIZE_ADDR_REG-1:0] addr_write_reg,
    output logic [SIZE_REG-1:0]      datain,
    output logic                     carry,
    output logic                     zero
);

    logic                accept;
    logic                is_mul;
    logic [SIZE_REG-1:0] opa;
    logic [SIZE_REG-1:0] opb;
    logic [SIZE_REG-1:0] alu_res;
    logic                alu_c;
    logic [SIZE_REG:0]   wide;

    assign accept = valid && ready;
    assign is_mul = (op == SIZE_OP'(OP_MUL));

    // The register file only sees our write one edge later, so bypass it.
    assign opa = (charge && (addr_write_reg == srcA)) ? datain : dataA;
    assign opb = (charge && (addr_write_reg == srcB)) ? datain : dataB;

    // Single-cycle ALU; MUL falls to the default and is handled elsewhere.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (op)
            SIZE_OP'(OP_ADD): begin
                wide    = {1'b0, opa} + {1'b0, opb};
                alu_res = wide[SIZE_REG-1:0];
                alu_c   = wide[SIZE_REG];
            end
            SIZE_OP'(OP_SUB): begin
                wide    = {1'b0, opa} - {1'b0, opb};
                alu_res = wide[SIZE_REG-1:0];
                alu_c   = wide[SIZE_REG];
            end
            SIZE_OP'(OP_AND): alu_res = opa & opb;
            SIZE_OP'(OP_OR):  alu_res = opa | opb;
            SIZE_OP'(OP_XOR): alu_res = opa ^ opb;
            SIZE_OP'(OP_SHL): alu_res = (opb >= SIZE_REG'(SIZE_REG)) ? '0 : (opa << opb);
            SIZE_OP'(OP_SHR): alu_res = (opb >= SIZE_REG'(SIZE_REG)) ? '0 : (opa >> opb);
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

`ifdef BLOCK_EXEC_MUL_EN
    logic [0:0]               state;
    logic [SIZE_ADDR_REG-1:0] mul_dest;
    logic                     mul_start;
    logic                     mul_done;
    logic [2*SIZE_REG-1:0]    mul_prod;

    assign ready     = (state == ST_IDLE);
    assign mul_start = accept && is_mul;

    // Issue FSM: a MUL holds off new ops until the multiplier reports done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mul_dest <= '0;
        end else if (mul_start) begin
            state    <= ST_MUL;
            mul_dest <= dest;
        end else if (mul_done) begin
            state    <= ST_IDLE;
        end
    end

    block_exec_mul #(.W(SIZE_REG)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (opa),
        .b       (opb),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign ready = 1'b1;
`endif

    // Writeback register: one-cycle charge pulse per completed op, flags held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            charge         <= 1'b0;
            addr_write_reg <= '0;
            datain         <= '0;
            carry          <= 1'b0;
            zero           <= 1'b0;
        end else begin
            charge <= 1'b0;
            if (accept && !is_mul) begin
                charge         <= 1'b1;
                addr_write_reg <= dest;
                datain         <= alu_res;
                carry          <= alu_c;
                zero           <= (alu_res == '0);
            end
`ifdef BLOCK_EXEC_MUL_EN
            if (mul_done) begin
                charge         <= 1'b1;
                addr_write_reg <= mul_dest;
                datain         <= mul_prod[SIZE_REG-1:0];
                carry          <= |mul_prod[2*SIZE_REG-1:SIZE_REG];
                zero           <= (mul_prod[SIZE_REG-1:0] == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_block_exec.sv
// tb/tb_block_exec.sv - directed self-checking bench for block_exec with a register file model
module tb_block_exec;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic       ready;
    logic [2:0] op;
    logic [4:0] dest;
    logic [4:0] srcA;
    logic [4:0] srcB;
    logic [7:0] dataA;
    logic [7:0] dataB;
    logic       charge;
    logic [4:0] addr_write_reg;
    logic [7:0] datain;
    logic       carry;
    logic       zero;

    logic [7:0] rf [32];
    logic       pl_en;
    logic [4:0] pl_addr;
    logic [7:0] pl_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    block_exec dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .ready          (ready),
        .op             (op),
        .dest           (dest),
        .srcA           (srcA),
        .srcB           (srcB),
        .dataA          (dataA),
        .dataB          (dataB),
        .charge         (charge),
        .addr_write_reg (addr_write_reg),
        .datain         (datain),
        .carry          (carry),
        .zero           (zero)
    );

    // Register file: asynchronous read, write on rising edge.
    always @(posedge clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (charge) rf[addr_write_reg] <= datain;
    end
    assign dataA = rf[srcA];
    assign dataB = rf[srcB];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Present an op at a negedge; it is accepted at the following posedge.
    task automatic issue(input logic [2:0] o, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        valid = 1'b1; op = o; dest = d; srcA = a; srcB = b;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; op = '0; dest = '0; srcA = '0; srcB = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 32; i++) load(5'(i), 8'h00);
        load(5'd10, 8'd7);   load(5'd11, 8'd5);
        load(5'd12, 8'd250); load(5'd13, 8'd10);
        load(5'd14, 8'd3);   load(5'd15, 8'd5);
        load(5'd16, 8'h55);  load(5'd17, 8'd1);
        load(5'd18, 8'd8);   load(5'd19, 8'd128);
        load(5'd20, 8'd3);   load(5'd21, 8'd20);
        load(5'd22, 8'd13);  load(5'd4, 8'h40);
        @(negedge clk);
        chk("rst_charge", 32'(charge), 32'd0);
        chk("rst_addr", 32'(addr_write_reg), 32'd0);
        chk("rst_datain", 32'(datain), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);

        // Valid while in reset must not be accepted.
        valid = 1'b1; op = 3'd0; dest = 5'd9; srcA = 5'd10; srcB = 5'd11;
        @(negedge clk);
        valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rstvalid_charge", 32'(charge), 32'd0);
        chk("rstvalid_datain", 32'(datain), 32'd0);

        // ADD 7+5 -> r2
        issue(3'd0, 5'd2, 5'd10, 5'd11);
        idle_cycle();
        chk("add_charge", 32'(charge), 32'd1);
        chk("add_addr", 32'(addr_write_reg), 32'd2);
        chk("add_datain", 32'(datain), 32'd12);
        chk("add_carry", 32'(carry), 32'd0);
        chk("add_zero", 32'(zero), 32'd0);
        chk("add_ready", 32'(ready), 32'd1);
        @(negedge clk);
        chk("add_pulse_end", 32'(charge), 32'd0);
        chk("add_rf", 32'(rf[2]), 32'd12);

        // ADD 250+10 -> 4 with carry
        issue(3'd0, 5'd30, 5'd12, 5'd13);
        idle_cycle();
        chk("addc_datain", 32'(datain), 32'd4);
        chk("addc_carry", 32'(carry), 32'd1);

        // SUB 3-5 -> 254 with borrow
        issue(3'd1, 5'd8, 5'd14, 5'd15);
        idle_cycle();
        chk("sub_datain", 32'(datain), 32'd254);
        chk("sub_carry", 32'(carry), 32'd1);

        // XOR 0x55^0x55 -> 0, zero set; flags then hold
        issue(3'd4, 5'd8, 5'd16, 5'd16);
        idle_cycle();
        chk("xor_datain", 32'(datain), 32'd0);
        chk("xor_zero", 32'(zero), 32'd1);
        chk("xor_carry", 32'(carry), 32'd0);
        @(negedge clk);
        chk("hold_zero", 32'(zero), 32'd1);
        chk("hold_charge", 32'(charge), 32'd0);

        // Shifts
        issue(3'd5, 5'd8, 5'd17, 5'd10);
        idle_cycle();
        chk("shl7", 32'(datain), 32'd128);
        issue(3'd5, 5'd8, 5'd17, 5'd18);
        idle_cycle();
        chk("shl8", 32'(datain), 32'd0);
        chk("shl8_zero", 32'(zero), 32'd1);
        issue(3'd6, 5'd8, 5'd19, 5'd20);
        idle_cycle();
        chk("shr3", 32'(datain), 32'd16);
        issue(3'd3, 5'd8, 5'd16, 5'd17);
        idle_cycle();
        chk("or", 32'(datain), 32'h55);
        issue(3'd2, 5'd8, 5'd16, 5'd17);
        idle_cycle();
        chk("and", 32'(datain), 32'h01);

        // Back-to-back dependents: r4 <- 7+5, r5 <- r4+1, r6 <- 1+r5
        issue(3'd0, 5'd4, 5'd10, 5'd11);
        issue(3'd0, 5'd5, 5'd4, 5'd17);
        chk("b2b1_datain", 32'(datain), 32'd12);
        issue(3'd0, 5'd6, 5'd17, 5'd5);
        chk("fwdA_datain", 32'(datain), 32'd13);
        chk("fwdA_addr", 32'(addr_write_reg), 32'd5);
        idle_cycle();
        chk("fwdB_datain", 32'(datain), 32'd14);
        @(negedge clk);
        chk("fwd_rf5", 32'(rf[5]), 32'd13);
        chk("fwd_rf6", 32'(rf[6]), 32'd14);

`ifdef BLOCK_EXEC_MUL_EN
        // MUL 20*13 = 260 -> 4, carry 1; ready low for 8 cycles
        issue(3'd7, 5'd7, 5'd21, 5'd22);
        idle_cycle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul_ready%0d", i), 32'(ready), 32'd0);
            chk($sformatf("mul_nocharge%0d", i), 32'(charge), 32'd0);
            @(negedge clk);
        end
        chk("mul_charge", 32'(charge), 32'd1);
        chk("mul_ready_back", 32'(ready), 32'd1);
        chk("mul_addr", 32'(addr_write_reg), 32'd7);
        chk("mul_datain", 32'(datain), 32'd4);
        chk("mul_carry", 32'(carry), 32'd1);
        @(negedge clk);
        chk("mul_pulse_end", 32'(charge), 32'd0);

        // Reset during the fourth MUL cycle aborts without a write
        issue(3'd7, 5'd9, 5'd21, 5'd22);
        idle_cycle();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("abort_nocharge%0d", i), 32'(charge), 32'd0);
            @(negedge clk);
        end
        chk("abort_rf9", 32'(rf[9]), 32'd0);
`else
        // Without the multiplier op 7 is a one-cycle NOP
        issue(3'd0, 5'd30, 5'd12, 5'd13);
        issue(3'd7, 5'd9, 5'd21, 5'd22);
        chk("nop_pre_carry", 32'(carry), 32'd1);
        idle_cycle();
        chk("nop_charge", 32'(charge), 32'd0);
        chk("nop_carry", 32'(carry), 32'd1);
        chk("nop_zero", 32'(zero), 32'd0);
        chk("nop_ready", 32'(ready), 32'd1);
        chk("nop_datain", 32'(datain), 32'd4);
        @(negedge clk);
        chk("nop_charge2", 32'(charge), 32'd0);
        chk("nop_rf9", 32'(rf[9]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
